// File: rtl/rams_sp_arb_pkg.sv
// Shared constants and types for the single-port RAM arbiter.
// Owner ids, default widths and the registered owner record.
package rams_sp_arb_pkg;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 16;

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } owner_t;
endpackage

// File: rtl/rams_sp_arb_sel.sv
// Combinational grant selector; round-robin under RAMS_SP_ARB_RR_EN, else data-over-instr.
// Zero latency; a solo request is always granted, never grants without a request.
module rams_sp_arb_sel
  import rams_sp_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic i_gnt,
  output logic d_gnt
);

`ifndef RAMS_SP_ARB_RR_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req && d_req) begin
`ifdef RAMS_SP_ARB_RR_EN
      // Favour whichever port did not win most recently.
      if (last_gnt == OWN_DATA) i_gnt = 1'b1;
      else                      d_gnt = 1'b1;
`else
      d_gnt = 1'b1;
`endif
    end else begin
      i_gnt = i_req;
      d_gnt = d_req;
    end
  end

endmodule

// File: rtl/rams_sp_arb.sv
// Arbitrates instr/data ports onto one single-port RAM, returning data one cycle later.
// Round-robin priority when RAMS_SP_ARB_RR_EN is defined, fixed data priority otherwise.
module rams_sp_arb
  import rams_sp_arb_pkg::*;
#(
  parameter int AW    = rams_sp_arb_pkg::AW,
  parameter int DW    = rams_sp_arb_pkg::DW,
  parameter int CNT_W = rams_sp_arb_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [DW-1:0]    i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DW-1:0]    d_rdata,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_di,
  input  logic [DW-1:0]    ram_dout,
  output logic [CNT_W-1:0] contention_cnt
);

  logic             sel_i_gnt, sel_d_gnt;
  logic             last_gnt;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rams_sp_arb_sel u_sel (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_gnt (last_gnt),
    .i_gnt    (sel_i_gnt),
    .d_gnt    (sel_d_gnt)
  );

  // No grants (and so no RAM writes) while reset is held.
  assign i_gnt = sel_i_gnt & rstn;
  assign d_gnt = sel_d_gnt & rstn;

`ifdef RAMS_SP_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (d_gnt)      last_gnt_d = OWN_DATA;
    else if (i_gnt) last_gnt_d = OWN_INSTR;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_gnt_q <= OWN_DATA;
    else       last_gnt_q <= last_gnt_d;
  end

  assign last_gnt = last_gnt_q;
`else
  assign last_gnt = OWN_DATA;
`endif

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (d_gnt) begin
      ram_we   = d_we;
      ram_addr = d_addr;
      ram_di   = d_wdata;
    end else if (i_gnt) begin
      ram_addr = i_addr;
    end
  end

  always_comb begin
    owner_d.vld = i_gnt | d_gnt;
    owner_d.id  = d_gnt ? OWN_DATA : OWN_INSTR;
    cnt_d       = cnt_q;
    if (i_req && d_req && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i_rvalid       = owner_q.vld && (owner_q.id == OWN_INSTR);
  assign d_rvalid       = owner_q.vld && (owner_q.id == OWN_DATA);
  assign i_rdata        = ram_dout;
  assign d_rdata        = ram_dout;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_rams_sp_arb.sv
// Scoreboard bench for rams_sp_arb with a behavioural 1-cycle RAM; honours RAMS_SP_ARB_RR_EN.
module tb_rams_sp_arb;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic        port;  // 0 = instr, 1 = data
    logic [31:0] data;
  } resp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_req, i_gnt, i_rvalid;
  logic [AW-1:0]    i_addr;
  logic [DW-1:0]    i_rdata;
  logic             d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0]    d_addr;
  logic [DW-1:0]    d_wdata, d_rdata;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_di, ram_dout;
  logic [CNT_W-1:0] contention_cnt;

  logic [31:0] mem [0:63];
  resp_t       exp_q[$];
  resp_t       mon_r;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        exp_i;

  always #5 clk = ~clk;

  rams_sp_arb #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout),
    .contention_cnt(contention_cnt)
  );

  // Single-port RAM, read-during-write returns old content.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:2]] <= ram_di;
    ram_dout <= mem[ram_addr[7:2]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic port, input logic [31:0] data);
    resp_t r;
    r.port = port;
    r.data = data;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (i_rvalid || d_rvalid) begin
      chk("rsp_both_valid", {63'd0, i_rvalid & d_rvalid}, 64'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: i_rvalid=%0b d_rvalid=%0b, expected no response at %0t",
                 i_rvalid, d_rvalid, $time);
      end else begin
        mon_r = exp_q.pop_front();
        chk("rsp_port", {63'd0, d_rvalid}, {63'd0, mon_r.port});
        chk("rsp_data", {32'd0, (d_rvalid ? d_rdata : i_rdata)}, {32'd0, mon_r.data});
      end
    end
  end

  initial begin
    for (int n = 0; n < 64; n++) mem[n] = n;
    rstn = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_rvalid", {63'd0, i_rvalid}, 64'd0);
    chk("rst_d_rvalid", {63'd0, d_rvalid}, 64'd0);
    chk("rst_cnt", {60'd0, contention_cnt}, 64'd0);
    tick();
    rstn = 1'b1;

    // Instr-only read of word 2.
    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    chk("t1_i_gnt", {63'd0, i_gnt}, 64'd1);
    chk("t1_d_gnt", {63'd0, d_gnt}, 64'd0);
    chk("t1_ram_addr", {32'd0, ram_addr}, 64'h8);
    chk("t1_ram_we", {63'd0, ram_we}, 64'd0);
    expect_rsp(1'b0, 32'h2);
    tick();
    i_req = 1'b0; i_addr = '0;

    // Data writes back to back, then read back; acks carry old content.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3C; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t2_d_gnt0", {63'd0, d_gnt}, 64'd1);
    chk("t2_ram_we", {63'd0, ram_we}, 64'd1);
    chk("t2_ram_addr", {32'd0, ram_addr}, 64'h3C);
    chk("t2_ram_di", {32'd0, ram_di}, 64'hFFFF_FFFF);
    expect_rsp(1'b1, 32'hF);
    tick();
    d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2_d_gnt1", {63'd0, d_gnt}, 64'd1);
    chk("t2_ram_di1", {32'd0, ram_di}, 64'hDEAD_BEEF);
    expect_rsp(1'b1, 32'hFFFF_FFFF);
    tick();
    d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    chk("t2_d_gnt2", {63'd0, d_gnt}, 64'd1);
    chk("t2_ram_we_rd", {63'd0, ram_we}, 64'd0);
    expect_rsp(1'b1, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0;

    // Contention for 4 cycles: instr word 1, data word 4.
    i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_cnt", {60'd0, contention_cnt}, k);
`ifdef RAMS_SP_ARB_RR_EN
      exp_i = ((k % 2) == 0);
`else
      exp_i = 1'b0;
`endif
      chk("t3_i_gnt", {63'd0, i_gnt}, {63'd0, exp_i});
      chk("t3_d_gnt", {63'd0, d_gnt}, {63'd0, ~exp_i});
      if (exp_i) expect_rsp(1'b0, 32'h1);
      else       expect_rsp(1'b1, 32'h4);
      tick();
    end
    d_req = 1'b0;
    @(negedge clk);
    chk("t3_i_gnt_after", {63'd0, i_gnt}, 64'd1);
    chk("t3_d_gnt_after", {63'd0, d_gnt}, 64'd0);
    chk("t3_cnt_after", {60'd0, contention_cnt}, 64'd4);
    expect_rsp(1'b0, 32'h1);
    tick();

    // Saturation: 20 more contention cycles from a count of 4.
    d_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
`ifdef RAMS_SP_ARB_RR_EN
      exp_i = ((k % 2) == 1);
`else
      exp_i = 1'b0;
`endif
      chk("t4_i_gnt", {63'd0, i_gnt}, {63'd0, exp_i});
      chk("t4_d_gnt", {63'd0, d_gnt}, {63'd0, ~exp_i});
      if (k == 11) chk("t4_cnt_reach", {60'd0, contention_cnt}, 64'hF);
      if (exp_i) expect_rsp(1'b0, 32'h1);
      else       expect_rsp(1'b1, 32'h4);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("t4_cnt_sat", {60'd0, contention_cnt}, 64'hF);
    tick();

    // Reset while a data read is in flight: its response must vanish.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    @(negedge clk);
    chk("t5_d_gnt_pre", {63'd0, d_gnt}, 64'd1);
    rstn = 1'b0; i_req = 1'b1; d_we = 1'b1;
    #1;
    chk("t5_i_gnt_rst", {63'd0, i_gnt}, 64'd0);
    chk("t5_d_gnt_rst", {63'd0, d_gnt}, 64'd0);
    chk("t5_ram_we_rst", {63'd0, ram_we}, 64'd0);
    chk("t5_cnt_rst", {60'd0, contention_cnt}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t5_d_rvalid_rst", {63'd0, d_rvalid}, 64'd0);
      chk("t5_i_rvalid_rst", {63'd0, i_rvalid}, 64'd0);
      chk("t5_gnt_rst", {62'd0, i_gnt, d_gnt}, 64'd0);
      chk("t5_cnt_held", {60'd0, contention_cnt}, 64'd0);
    end
    tick();
    rstn = 1'b1; i_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("t5_d_gnt_post", {63'd0, d_gnt}, 64'd1);
    chk("t5_d_rvalid_post", {63'd0, d_rvalid}, 64'd0);
    expect_rsp(1'b1, 32'h2);
    tick();

    // First contention after reset exercises the reset priority pointer.
    i_req = 1'b1; i_addr = 32'h4;
    @(negedge clk);
`ifdef RAMS_SP_ARB_RR_EN
    exp_i = 1'b1;
`else
    exp_i = 1'b0;
`endif
    chk("t6_i_gnt", {63'd0, i_gnt}, {63'd0, exp_i});
    chk("t6_d_gnt", {63'd0, d_gnt}, {63'd0, ~exp_i});
    if (exp_i) expect_rsp(1'b0, 32'h1);
    else       expect_rsp(1'b1, 32'h2);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("t6_cnt", {60'd0, contention_cnt}, 64'd1);

    repeat (3) tick();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
